gsim_out_buf: RTL

GSIM_OUT_BUF -- requirements
Module: gsim_out_buf

---
 rtl/gsim_out_buf_pkg.sv | 15 +
 rtl/gsim_out_buf_round_sat.sv | 42 ++++
 rtl/gsim_out_buf.sv | 129 ++++++++++++
 3 files changed

// File: rtl/gsim_out_buf_pkg.sv
// Shared constants for the solver output path.
// Holds the FSM state encoding and the default fixed-point / frame sizes so
// the solver and gsim_out_buf agree on the same numbers.
package gsim_out_buf_pkg;

  localparam int FRAC_BITS_DEF = 16;  // fractional bits of Q16.16 words
  localparam int N_VAR_DEF     = 16;  // solution words per frame
  localparam int OUT_W_DEF     = 16;  // rounded/saturated output width

  typedef enum logic {
    FILL  = 1'b0,
    DRAIN = 1'b1
  } state_t;

endpackage

// File: rtl/gsim_out_buf_round_sat.sv
// q16_round_sat: combinational round-half-up and saturate of a signed
// fixed-point word to an OUT_W-bit signed integer.
// Ports:
//   x_in  [31:0]      signed fixed-point input (FRAC_BITS fractional bits)
//   q_out [OUT_W-1:0] rounded, saturated result
//   sat               result was clipped to the positive or negative limit
module q16_round_sat
  import gsim_out_buf_pkg::*;
#(
  parameter int FRAC_BITS = FRAC_BITS_DEF,
  parameter int OUT_W     = OUT_W_DEF
) (
  input  logic [31:0]      x_in,
  output logic [OUT_W-1:0] q_out,
  output logic             sat
);

  // 33 bits so adding the rounding constant to values near +max cannot wrap.
  localparam logic signed [32:0] RND_K = 33'sd1 <<< (FRAC_BITS - 1);
  localparam logic signed [32:0] MAX_V = (33'sd1 <<< (OUT_W - 1)) - 33'sd1;
  localparam logic signed [32:0] MIN_V = -(33'sd1 <<< (OUT_W - 1));

  logic signed [32:0] sum_s;
  logic signed [32:0] shr_s;

  // Round half toward +inf, then clip to the signed OUT_W range.
  always_comb begin
    sum_s = $signed({x_in[31], x_in}) + RND_K;
    shr_s = sum_s >>> FRAC_BITS;
    if (shr_s > MAX_V) begin
      q_out = {1'b0, {(OUT_W-1){1'b1}}};
      sat   = 1'b1;
    end else if (shr_s < MIN_V) begin
      q_out = {1'b1, {(OUT_W-1){1'b0}}};
      sat   = 1'b1;
    end else begin
      q_out = shr_s[OUT_W-1:0];
      sat   = 1'b0;
    end
  end

endmodule

// File: rtl/gsim_out_buf.sv
// gsim_out_buf: collects one frame of N_VAR solver words, converts each to a
// rounded/saturated OUT_W-bit integer, then streams them out with a
// valid/ready handshake.
// Ports:
//   clk, reset_n        clock, async active-low reset
//   in_valid, x_in      solver strobe; x_in is valid the cycle after in_valid
//   out_valid/out_ready output handshake
//   q_out, q_idx        current word and its variable index
//   frame_done          one-cycle pulse after the last word is accepted
//   sat_flag, drop_flag sticky saturation / discarded-input indicators
module gsim_out_buf
  import gsim_out_buf_pkg::*;
#(
  parameter int FRAC_BITS = FRAC_BITS_DEF,
  parameter int N_VAR     = N_VAR_DEF,
  parameter int OUT_W     = OUT_W_DEF
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  input  logic [31:0]      x_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] q_out,
  output logic [3:0]       q_idx,
  output logic             frame_done,
  output logic             sat_flag,
  output logic             drop_flag
);

  localparam int IDX_W = (N_VAR > 1) ? $clog2(N_VAR) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_VAR - 1);
  localparam logic [IDX_W-1:0] ONE_IDX  = IDX_W'(1);
  localparam logic [IDX_W-1:0] ZERO_IDX = IDX_W'(0);

  state_t           state_r;
  logic             cap_en_r;
  logic [IDX_W-1:0] wr_idx_r;
  logic [IDX_W-1:0] rd_idx_r;
  logic [IDX_W-1:0] next_rd_s;
  logic [OUT_W-1:0] word_buf_r [N_VAR];
  logic [OUT_W-1:0] conv_q_s;
  logic             conv_sat_s;
  logic             wr_en_s;
  logic             hshake_s;

  q16_round_sat #(
    .FRAC_BITS (FRAC_BITS),
    .OUT_W     (OUT_W)
  ) u_round_sat (
    .x_in  (x_in),
    .q_out (conv_q_s),
    .sat   (conv_sat_s)
  );

  assign wr_en_s   = cap_en_r && (state_r == FILL);
  assign hshake_s  = out_valid && out_ready;
  assign next_rd_s = rd_idx_r + ONE_IDX;

  // Word buffer: one write port (capture) and one read port; never reset.
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      word_buf_r[wr_idx_r] <= conv_q_s;
    end
  end

  // Frame FSM with registered handshake outputs and sticky flags.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r    <= FILL;
      cap_en_r   <= 1'b0;
      wr_idx_r   <= ZERO_IDX;
      rd_idx_r   <= ZERO_IDX;
      out_valid  <= 1'b0;
      q_out      <= {OUT_W{1'b0}};
      q_idx      <= 4'd0;
      frame_done <= 1'b0;
      sat_flag   <= 1'b0;
      drop_flag  <= 1'b0;
    end else begin
      // x_in lags in_valid by one cycle, so capture on the delayed strobe.
      cap_en_r   <= in_valid;
      frame_done <= 1'b0;
      case (state_r)
        FILL: begin
          out_valid <= 1'b0;
          if (cap_en_r) begin
            if (conv_sat_s) begin
              sat_flag <= 1'b1;
            end
            if (wr_idx_r == LAST_IDX) begin
              state_r   <= DRAIN;
              wr_idx_r  <= ZERO_IDX;
              out_valid <= 1'b1;
              q_idx     <= 4'd0;
              // With a single-word frame, word 0 is being written this edge.
              q_out     <= (N_VAR == 1) ? conv_q_s : word_buf_r[0];
            end else begin
              wr_idx_r <= wr_idx_r + ONE_IDX;
            end
          end
        end
        DRAIN: begin
          // No room for a new frame until the drain finishes.
          if (cap_en_r) begin
            drop_flag <= 1'b1;
          end
          if (hshake_s) begin
            if (rd_idx_r == LAST_IDX) begin
              state_r    <= FILL;
              rd_idx_r   <= ZERO_IDX;
              out_valid  <= 1'b0;
              frame_done <= 1'b1;
            end else begin
              rd_idx_r <= next_rd_s;
              q_out    <= word_buf_r[next_rd_s];
              q_idx    <= 4'(next_rd_s);
            end
          end
        end
        default: begin
          state_r   <= FILL;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
